// File: rtl/uart_port_scheduler.sv
// rtl/uart_port_scheduler.sv - round-robin UART TX sharing with start/idle handshake, RX FIFO and error counters
module uart_port_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int RX_DEPTH  = 8,
  parameter int ERR_CNT_W = 8,
  localparam int IW = $clog2(NUM_REQ),
  localparam int AW = $clog2(RX_DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*9-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [IW-1:0]          grant_id,
  output logic                   busy,
  output logic                   uart_start_tx,
  output logic [8:0]             uart_tx_data,
  input  logic                   uart_tx_idle,
  input  logic                   uart_rx_full,
  input  logic                   uart_frame_error,
  input  logic                   uart_parity_error,
  input  logic [8:0]             uart_rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic [8:0]             rx_data,
  output logic [AW:0]            rx_count,
  output logic                   rx_overrun,
  output logic [ERR_CNT_W-1:0]   frame_err_cnt,
  output logic [ERR_CNT_W-1:0]   parity_err_cnt,
  input  logic                   stat_clr
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_IDLE} state_t;

  state_t          r_state, w_next_state;
  logic [IW-1:0]   r_rr_ptr, w_winner, w_next_ptr;
  logic [1:0]      r_to_cnt;
  logic            w_found, w_accept;

  // Search starts at r_rr_ptr so the requester after the last winner has top priority.
  always_comb begin
    int j;
    j = 0;
    w_winner = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(r_rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!w_found && req_valid[IW'(j)]) begin
        w_found = 1'b1;
        w_winner = IW'(j);
      end
    end
    w_next_ptr = (w_winner == IW'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_accept = 1'b0;
    uart_start_tx = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (reset && w_found && uart_tx_idle) begin
          w_accept = 1'b1;
          w_next_state = S_START;
        end
      end
      S_START: begin
        uart_start_tx = 1'b1;
        w_next_state = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        // Give up after 4 cycles if the UART never reports the frame started.
        if (!uart_tx_idle)         w_next_state = S_WAIT_IDLE;
        else if (r_to_cnt == 2'd3) w_next_state = S_IDLE;
      end
      S_WAIT_IDLE: begin
        if (uart_tx_idle) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign req_ready = w_accept ? (NUM_REQ'(1) << w_winner) : '0;
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      uart_tx_data <= '0;
      grant_id     <= '0;
      r_rr_ptr     <= '0;
      r_to_cnt     <= '0;
    end else begin
      if (w_accept) begin
        uart_tx_data <= req_data[9*w_winner +: 9];
        grant_id     <= w_winner;
        r_rr_ptr     <= w_next_ptr;
      end
      r_to_cnt <= (r_state == S_WAIT_BUSY) ? r_to_cnt + 1'b1 : 2'd0;
    end
  end

  logic [8:0]    r_mem [RX_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_rx_full_d, r_fe_d, r_pe_d;
  logic          w_push, w_pop, w_full, w_write;

  assign w_push  = uart_rx_full & ~r_rx_full_d;
  assign w_pop   = rx_valid & rx_ready;
  assign w_full  = (r_count == (AW+1)'(RX_DEPTH));
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign w_write = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wr_ptr] <= uart_rx_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rx_valid = (r_count != '0);
  assign rx_data  = r_mem[r_rd_ptr];
  assign rx_count = r_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rx_full_d    <= 1'b0;
      r_fe_d         <= 1'b0;
      r_pe_d         <= 1'b0;
      rx_overrun     <= 1'b0;
      frame_err_cnt  <= '0;
      parity_err_cnt <= '0;
    end else begin
      r_rx_full_d <= uart_rx_full;
      r_fe_d      <= uart_frame_error;
      r_pe_d      <= uart_parity_error;
      if (stat_clr) begin
        rx_overrun     <= 1'b0;
        frame_err_cnt  <= '0;
        parity_err_cnt <= '0;
      end else begin
        if (w_push && w_full && !w_pop) rx_overrun <= 1'b1;
        if (uart_frame_error && !r_fe_d && frame_err_cnt != {ERR_CNT_W{1'b1}})
          frame_err_cnt <= frame_err_cnt + 1'b1;
        if (uart_parity_error && !r_pe_d && parity_err_cnt != {ERR_CNT_W{1'b1}})
          parity_err_cnt <= parity_err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_port_scheduler.sv
// tb/tb_uart_port_scheduler.sv - directed checks of arbitration, UART handshake, RX FIFO and counters
module tb_uart_port_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [35:0] req_data;
  logic [3:0]  req_ready;
  logic [1:0]  grant_id;
  logic        busy;
  logic        uart_start_tx;
  logic [8:0]  uart_tx_data;
  logic        uart_tx_idle;
  logic        uart_rx_full;
  logic        uart_frame_error;
  logic        uart_parity_error;
  logic [8:0]  uart_rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [8:0]  rx_data;
  logic [3:0]  rx_count;
  logic        rx_overrun;
  logic [7:0]  frame_err_cnt;
  logic [7:0]  parity_err_cnt;
  logic        stat_clr;

  int checks = 0;
  int errors = 0;

  logic [8:0] d [4];

  typedef struct {
    logic [3:0] mask;
    int         w;
  } vec_t;
  vec_t vecs [13];

  always #5 clk = ~clk;

  uart_port_scheduler dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .grant_id(grant_id), .busy(busy),
    .uart_start_tx(uart_start_tx), .uart_tx_data(uart_tx_data), .uart_tx_idle(uart_tx_idle),
    .uart_rx_full(uart_rx_full), .uart_frame_error(uart_frame_error),
    .uart_parity_error(uart_parity_error), .uart_rx_data(uart_rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .rx_count(rx_count),
    .rx_overrun(rx_overrun), .frame_err_cnt(frame_err_cnt), .parity_err_cnt(parity_err_cnt),
    .stat_clr(stat_clr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arrives in S_IDLE at posedge+1, leaves in S_IDLE at posedge+1 with mask still driven.
  task automatic run_frame(input logic [3:0] mask, input int w);
    req_valid = mask;
    #1;
    chk("accept_ready", 32'(req_ready), 32'(4'b0001 << w));
    chk("accept_busy", 32'(busy), 32'd0);
    tick();
    chk("start_pulse", 32'(uart_start_tx), 32'd1);
    chk("grant_id", 32'(grant_id), 32'(w));
    chk("tx_data", 32'(uart_tx_data), 32'(d[w]));
    chk("ready_in_start", 32'(req_ready), 32'd0);
    tick();
    chk("start_one_cycle", 32'(uart_start_tx), 32'd0);
    uart_tx_idle = 1'b0;
    tick();
    tick();
    chk("tx_data_held", 32'(uart_tx_data), 32'(d[w]));
    chk("ready_in_frame", 32'(req_ready), 32'd0);
    uart_tx_idle = 1'b1;
    #1;
    chk("ready_at_idle_rise", 32'(req_ready), 32'd0);
    tick();
  endtask

  task automatic rx_push(input logic [8:0] data, input int hold);
    uart_rx_data = data;
    uart_rx_full = 1'b1;
    for (int i = 0; i < hold; i++) tick();
    uart_rx_full = 1'b0;
    tick();
  endtask

  initial begin
    d[0] = 9'h011; d[1] = 9'h122; d[2] = 9'h0A5; d[3] = 9'h1F3;
    vecs[0]  = '{4'b0100, 2};
    vecs[1]  = '{4'b1111, 3};
    vecs[2]  = '{4'b1111, 0};
    vecs[3]  = '{4'b1111, 1};
    vecs[4]  = '{4'b1111, 2};
    vecs[5]  = '{4'b1111, 3};
    vecs[6]  = '{4'b1111, 0};
    vecs[7]  = '{4'b0100, 2};
    vecs[8]  = '{4'b0100, 2};
    vecs[9]  = '{4'b0001, 0};
    vecs[10] = '{4'b1001, 3};
    vecs[11] = '{4'b1010, 1};
    vecs[12] = '{4'b0011, 0};

    req_data = {d[3], d[2], d[1], d[0]};
    reset = 1'b0;
    req_valid = '0;
    uart_tx_idle = 1'b1;
    uart_rx_full = 1'b0;
    uart_frame_error = 1'b0;
    uart_parity_error = 1'b0;
    uart_rx_data = '0;
    rx_ready = 1'b0;
    stat_clr = 1'b0;
    tick();
    tick();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_start", 32'(uart_start_tx), 32'd0);
    chk("rst_tx_data", 32'(uart_tx_data), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_count", 32'(rx_count), 32'd0);
    chk("rst_overrun", 32'(rx_overrun), 32'd0);
    chk("rst_fe_cnt", 32'(frame_err_cnt), 32'd0);
    reset = 1'b1;
    tick();

    for (int v = 0; v < 13; v++) run_frame(vecs[v].mask, vecs[v].w);
    req_valid = '0;
    tick();

    // UART ignores startTx: timeout back to idle, then re-arbitration
    req_valid = 4'b0001;
    #1;
    chk("to_accept", 32'(req_ready), 32'b0001);
    tick();
    chk("to_start", 32'(uart_start_tx), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("to_wait_busy", 32'(busy), 32'd1);
    end
    tick();
    chk("to_back_idle", 32'(busy), 32'd0);
    chk("to_rearb", 32'(req_ready), 32'b0001);
    req_valid = '0;
    #1;
    chk("withdraw_no_ready", 32'(req_ready), 32'd0);
    tick();
    chk("withdraw_no_xfer", 32'(busy), 32'd0);

    // RX overflow, held rx_full, simultaneous push/pop at full
    rx_push(9'd1, 3);
    chk("held_full_one_push", 32'(rx_count), 32'd1);
    for (int i = 2; i <= 9; i++) rx_push(9'(i), 1);
    chk("rx_count_full", 32'(rx_count), 32'd8);
    chk("rx_overrun_set", 32'(rx_overrun), 32'd1);
    chk("rx_head_1", 32'(rx_data), 32'd1);
    uart_rx_data = 9'd10;
    uart_rx_full = 1'b1;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    uart_rx_full = 1'b0;
    chk("pushpop_full_count", 32'(rx_count), 32'd8);
    for (int i = 2; i <= 9; i++) begin
      chk("rx_order", 32'(rx_data), (i == 9) ? 32'd10 : 32'(i));
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
    end
    chk("rx_empty_valid", 32'(rx_valid), 32'd0);
    chk("rx_empty_count", 32'(rx_count), 32'd0);
    chk("overrun_sticky", 32'(rx_overrun), 32'd1);

    // Saturating error counters and stat_clr priority
    for (int i = 0; i < 300; i++) begin
      uart_frame_error = 1'b1;
      tick();
      uart_frame_error = 1'b0;
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      uart_parity_error = 1'b1;
      tick();
      tick();
    end
    uart_parity_error = 1'b0;
    chk("fe_saturate", 32'(frame_err_cnt), 32'd255);
    chk("pe_count", 32'(parity_err_cnt), 32'd1);
    tick();
    uart_parity_error = 1'b1;
    tick();
    uart_parity_error = 1'b0;
    tick();
    chk("pe_count2", 32'(parity_err_cnt), 32'd2);
    uart_frame_error = 1'b1;
    uart_parity_error = 1'b1;
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("clr_fe", 32'(frame_err_cnt), 32'd0);
    chk("clr_pe", 32'(parity_err_cnt), 32'd0);
    chk("clr_overrun", 32'(rx_overrun), 32'd0);
    tick();
    chk("level_no_inc", 32'(frame_err_cnt), 32'd0);
    uart_frame_error = 1'b0;
    uart_parity_error = 1'b0;
    tick();

    // Reset mid-frame with words buffered
    for (int i = 0; i < 3; i++) rx_push(9'(i + 20), 1);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    uart_tx_idle = 1'b0;
    tick();
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_count", 32'(rx_count), 32'd3);
    reset = 1'b0;
    tick();
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(rx_valid), 32'd0);
    chk("mid_rst_count", 32'(rx_count), 32'd0);
    chk("mid_rst_start", 32'(uart_start_tx), 32'd0);
    chk("mid_rst_grant", 32'(grant_id), 32'd0);
    uart_tx_idle = 1'b1;
    reset = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("rr_ptr_reset", 32'(req_ready), 32'b0001);
    req_valid = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
